// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI-Lite response codes and read-channel state type.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
endpackage

// File: rtl/axi_lite_ram_core.sv
// axi_lite_ram_core: word RAM with one byte-enabled write port and one registered read port.
// Ports:
//   clk, rst_n              clock, async active-low reset (read register only, memory is never cleared)
//   i_we/i_widx/i_wdata/i_wstrb   write enable, word index, data, byte lanes
//   i_re/i_ridx             read enable, word index
//   o_rdata                 registered read data, updated only on i_re (old data on same-edge write)
module axi_lite_ram_core #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int IW = $clog2(DEPTH_WORDS),
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [IW-1:0]         i_widx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [SW-1:0]         i_wstrb,
    input  logic                  i_re,
    input  logic [IW-1:0]         i_ridx,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk)
        if (i_we)
            for (int i = 0; i < SW; i++)
                if (i_wstrb[i]) r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_ridx];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI4-Lite slave backed by an internal word RAM.
// Ports: clk, rst_n (async active-low); AXI-Lite AW/W/B/AR/R channels (S_AXI_*), PROT ignored.
// Write path holds AW and W independently and commits when both are held and no B is pending.
// Read path is a two-state FSM with registered RDATA/RRESP.
// Out-of-range accesses return SLVERR without touching memory; reads return zero.
// Optional macro AXI_RAM_ALIGN_CHECK_EN: misaligned addresses also return SLVERR.
module axi_lite_ram_slave
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(DEPTH_WORDS);

    // Borrow out of the subtraction flags addr < BASE_ADDR without a constant compare.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDR};
        addr_ok = !d[ADDR_WIDTH] && ((d[ADDR_WIDTH-1:0] >> (LSB + IW)) == '0);
`ifdef AXI_RAM_ALIGN_CHECK_EN
        addr_ok = addr_ok && (a[LSB-1:0] == '0);
`endif
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] d;
        d = a - BASE_ADDR;
        addr_idx = d[LSB +: IW];
    endfunction

    logic                    r_aw_held, r_w_held, r_bvalid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [1:0]              r_bresp, r_rresp;
    r_state_t                r_state, w_next;
    logic                    w_aw_hs, w_w_hs, w_commit, w_aw_ok, w_ar_hs;
    logic [DATA_WIDTH-1:0]   w_core_rdata;
    logic                    w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign w_aw_hs  = S_AXI_AWVALID && !r_aw_held;
    assign w_w_hs   = S_AXI_WVALID && !r_w_held;
    assign w_commit = r_aw_held && r_w_held && !r_bvalid;
    assign w_aw_ok  = addr_ok(r_awaddr);
    assign w_ar_hs  = S_AXI_ARVALID && (r_state == R_IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= S_AXI_AWADDR;
            end else if (w_commit) r_aw_held <= 1'b0;
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end else if (w_commit) r_w_held <= 1'b0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) r_bvalid <= 1'b0;
        end

    always_comb begin
        w_next = r_state;
        if (r_state == R_IDLE && S_AXI_ARVALID) w_next = R_DATA;
        if (r_state == R_DATA && S_AXI_RREADY) w_next = R_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_rresp <= RESP_OKAY;
        end else begin
            r_state <= w_next;
            if (w_ar_hs) r_rresp <= addr_ok(S_AXI_ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end

    axi_lite_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_commit && w_aw_ok),
        .i_widx (addr_idx(r_awaddr)),
        .i_wdata(r_wdata),
        .i_wstrb(r_wstrb),
        .i_re   (w_ar_hs && addr_ok(S_AXI_ARADDR)),
        .i_ridx (addr_idx(S_AXI_ARADDR)),
        .o_rdata(w_core_rdata)
    );

    // Errored reads leave the core register untouched, so zero is forced here.
    assign S_AXI_RDATA   = (r_rresp == RESP_SLVERR) ? '0 : w_core_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_AWREADY = !r_aw_held;
    assign S_AXI_WREADY  = !r_w_held;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: directed self-checking bench for axi_lite_ram_slave.
module tb_axi_lite_ram_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic [1:0]  bresp, rresp;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    axi_lite_ram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present AW and/or W; each valid drops after the edge where its ready was seen.
    task automatic write_ch(input logic aw_en, input logic w_en, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        logic ra, rw;
        awaddr = a; wdata = d; wstrb = s; awvalid = aw_en; wvalid = w_en;
        for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
            ra = awready; rw = wready;
            tick();
            if (ra) awvalid = 0;
            if (rw) wvalid = 0;
        end
        if (awvalid || wvalid) begin
            chk("wr_timeout", {awvalid, wvalid}, 2'b00);
            awvalid = 0; wvalid = 0;
        end
    endtask

    task automatic get_b(input string tag, input logic [1:0] exp);
        bready = 1;
        for (int n = 0; n < 20 && !bvalid; n++) tick();
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_bresp"}, bresp, exp);
        tick();
        bready = 0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] exp);
        write_ch(1, 1, a, d, s);
        get_b(tag, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic [1:0] exp_r);
        araddr = a; arvalid = 1;
        for (int n = 0; n < 20 && !arready; n++) tick();
        tick();
        arvalid = 0;
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_rresp"}, rresp, exp_r);
        rready = 1;
        tick();
        rready = 0;
        chk({tag, "_rvalid_clr"}, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1;
        tick();

        // AW first, W two cycles later; B appears one edge after the W handshake.
        write_ch(1, 0, 32'h10, 32'h0, 4'h0);
        tick(2);
        chk("aw_held_awready", awready, 1'b0);
        chk("aw_only_bvalid", bvalid, 1'b0);
        write_ch(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wlat_bvalid_lo", bvalid, 1'b0);
        tick();
        chk("wlat_bvalid_hi", bvalid, 1'b1);
        get_b("w10", 2'b00);
        rd("r10", 32'h10, 32'hDEADBEEF, 2'b00);

        // WSTRB=0 completes OKAY without changing memory.
        wr("wstrb0", 32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
        rd("r10_strb0", 32'h10, 32'hDEADBEEF, 2'b00);
`ifdef AXI_RAM_ALIGN_CHECK_EN
        rd("r11", 32'h11, 32'h0, 2'b10);
        rd("r31", 32'h31, 32'h0, 2'b10);
`else
        rd("r11", 32'h11, 32'hDEADBEEF, 2'b00);
`endif

        // W before AW, single byte lane.
        wr("w20", 32'h20, 32'h11223344, 4'hF, 2'b00);
        write_ch(0, 1, 32'h0, 32'h00AA0000, 4'b0100);
        chk("w_held_wready", wready, 1'b0);
        write_ch(1, 0, 32'h20, 32'h0, 4'h0);
        get_b("w20b", 2'b00);
        rd("r20", 32'h20, 32'h11AA3344, 2'b00);

        // BREADY held low: B stable, second write held until B handshake.
        write_ch(1, 1, 32'h40, 32'hA5A5A5A5, 4'hF);
        tick();
        write_ch(1, 1, 32'h44, 32'h5A5A5A5A, 4'hF);
        chk("held2_awready", awready, 1'b0);
        chk("held2_wready", wready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bstall_bvalid", bvalid, 1'b1);
            chk("bstall_bresp", bresp, 2'b00);
        end
        bready = 1;
        tick();
        bready = 0;
        chk("b1_done_bvalid", bvalid, 1'b0);
        tick();
        chk("b2_commit_bvalid", bvalid, 1'b1);
        get_b("w44", 2'b00);
        rd("r40", 32'h40, 32'hA5A5A5A5, 2'b00);
        rd("r44", 32'h44, 32'h5A5A5A5A, 2'b00);

        // Out of range at DEPTH_WORDS boundary.
        wr("wffc", 32'h0FFC, 32'hCAFEF00D, 4'hF, 2'b00);
        wr("w1000", 32'h1000, 32'h12345678, 4'hF, 2'b10);
        rd("r1000", 32'h1000, 32'h0, 2'b10);
        rd("rffc", 32'h0FFC, 32'hCAFEF00D, 2'b00);

        // Commit and AR to the same word at the same edge: read sees old data.
        wr("w30", 32'h30, 32'h1, 4'hF, 2'b00);
        write_ch(1, 1, 32'h30, 32'h1, 4'hF);
        tick();
        write_ch(1, 1, 32'h30, 32'h2, 4'hF);
        bready = 1;
        tick();
        bready = 0;
        araddr = 32'h30; arvalid = 1;
        tick();
        arvalid = 0;
        chk("same_rvalid", rvalid, 1'b1);
        chk("same_rdata", rdata, 32'h1);
        chk("same_bvalid", bvalid, 1'b1);
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        rd("r30_new", 32'h30, 32'h2, 2'b00);

        // Reset with AW held and W pending: nothing written, outputs back to reset values.
        wr("w50", 32'h50, 32'h77, 4'hF, 2'b00);
        wr("w2000", 32'h2000, 32'h1, 4'hF, 2'b10);
        araddr = 32'h1000; arvalid = 1;
        tick();
        arvalid = 0;
        write_ch(1, 0, 32'h50, 32'h0, 4'h0);
        #2 rst_n = 0;
        #1;
        chk("arst_awready", awready, 1'b1);
        chk("arst_wready", wready, 1'b1);
        chk("arst_arready", arready, 1'b1);
        chk("arst_bvalid", bvalid, 1'b0);
        chk("arst_rvalid", rvalid, 1'b0);
        chk("arst_bresp", bresp, 2'b00);
        chk("arst_rresp", rresp, 2'b00);
        chk("arst_rdata", rdata, 32'h0);
        tick();
        rst_n = 1;
        tick();
        write_ch(0, 1, 32'h0, 32'h99, 4'hF);
        tick(2);
        chk("post_rst_no_commit", bvalid, 1'b0);
        rd("r50", 32'h50, 32'h77, 2'b00);
        write_ch(1, 0, 32'h54, 32'h0, 4'h0);
        get_b("w54", 2'b00);
        rd("r54", 32'h54, 32'h99, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
